alu_exec: RTL and testbench
===========================

Name: alu_exec

Overview:
- 32-bit MIPS-style execute-stage ALU: AND, OR, ADD, SUB, SLT, NOR, selected by a 3-bit control code from the ALU-control decoder.
- Result and flags are registered: one-cycle latency, with a valid strobe into the EX/MEM boundary.
- A zero flag supports beq/bne branch resolution.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and ALUctrl are valid this cycle.
- A  input  WIDTH  operand A (rs).
- B  input  WIDTH  operand B (rt or immediate).
- ALUctrl  input  3  operation select.
- res  output  WIDTH  registered result.
- zero  output  1  registered; 1 when res == 0.
- overflow  output  1  registered; signed overflow for ADD/SUB, else 0.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- Reset: rst_n low clears res=0, zero=1, overflow=0, out_valid=0 immediately (asynchronous). Release is synchronous to clk.
- Reset mid-operation discards any in-flight result.
- Opcode map:
  - 000 AND: A & B.
  - 001 OR: A | B.
  - 010 ADD: A + B, modulo 2^WIDTH.
  - 110 SUB: A - B, computed as A + ~B + 1, modulo 2^WIDTH.
  - 111 SLT: res = {31'b0, lt}, where lt = signed(A) < signed(B). lt is derived from the subtractor as sign(A-B) XOR overflow(A-B).
  - 100 NOR: ~(A | B).
  - 011, 101 (reserved): res = 0, overflow = 0.
- Carry-out is discarded; no exceptions or traps are raised.
- overflow:
  - ADD: A and B have the same sign and the result sign differs.
  - SUB: A and B have different signs and the result sign differs from A.
  - 0 for all other opcodes, including SLT.
- zero is computed from the registered result value in the same cycle, so zero == (res == 0) always holds.
- Latency: inputs sampled at posedge k when in_valid=1 appear on res/zero/overflow after posedge k; out_valid=1 for that cycle.
- in_valid=0 at a posedge: res/zero/overflow hold their previous values and out_valid drops to 0.
- Back-to-back valid inputs: one result per cycle. No stall and no backpressure.
- X/undefined ALUctrl is treated as reserved (res=0); the bench always drives a defined code.
- The combinational next-state datapath is purely combinational. Only the output registers are clocked.

Decomposition:
- Package alu_pkg:
  - localparams ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_NOR=3'b100, ALU_SUB=3'b110, ALU_SLT=3'b111.
  - WIDTH default.
- Sub-module alu_addsub: combinational WIDTH-bit adder/subtractor with a sub control input.
  - Outputs: sum, signed overflow, sign.
  - Shared by ADD, SUB and SLT.
- Top alu_exec holds the opcode mux, the zero detect and the output registers.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> res=0, zero=1, overflow=0, out_valid=0 without a clock edge; release, no in_valid -> outputs hold.
- A=0x00000000, B=0xDEADBEEF, in_valid=1, sweep ALUctrl. Next cycle:
  - AND: res=0x00000000, zero=1.
  - OR: res=0xDEADBEEF, zero=0.
  - ADD: res=0xDEADBEEF, zero=0.
  - SUB: res=0x21524111, overflow=0.
  - SLT: res=0, zero=1 (0 is not < negative B).
- Overflow:
  - ADD A=0x7FFFFFFF, B=1 -> res=0x80000000, overflow=1.
  - SUB A=0x80000000, B=1 -> res=0x7FFFFFFF, overflow=1.
  - ADD A=0xFFFFFFFF, B=1 -> res=0, zero=1, overflow=0.
- SLT signed edge cases:
  - A=0x80000000, B=0x7FFFFFFF -> res=1.
  - A=5, B=5 -> res=0, zero=1.
  - A=0xFFFFFFFF, B=0 -> res=1.
- NOR and reserved codes:
  - NOR A=0x0F0F0F0F, B=0x00FF00FF -> res=0xF000F000.
  - ALUctrl=011 or 101 -> res=0, zero=1.
- Pipelining: apply valid ops on consecutive cycles, then in_valid=0 -> each result appears exactly one cycle later, out_valid tracks in_valid, and the last result holds.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU slice.
//   ALU_WIDTH      : default operand/result width in bits
//   ALU_*          : 3-bit operation codes driven by the ALU-control decoder
//   alu_uses_sub() : true for the codes that steer the shared adder into
//                    subtract mode (SUB and SLT)
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // SLT is resolved from A - B, so it shares the subtract path with SUB.
    function automatic logic alu_uses_sub(input logic [2:0] op);
        logic uses_sub;
        case (op)
            ALU_SUB: uses_sub = 1'b1;
            ALU_SLT: uses_sub = 1'b1;
            default: uses_sub = 1'b0;
        endcase
        return uses_sub;
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// -----------------------------------------------------------------------------
// alu_addsub
// Purely combinational WIDTH-bit adder/subtractor shared by ADD, SUB and SLT.
// Subtraction is formed as a + ~b + 1; the carry-out is not produced.
// Ports:
//   a_i    : operand A
//   b_i    : operand B
//   sub_i  : 1 = compute a_i - b_i, 0 = compute a_i + b_i
//   sum_o  : result modulo 2^WIDTH
//   ovf_o  : two's-complement signed overflow of the selected operation
//   sign_o : most significant bit of sum_o
// -----------------------------------------------------------------------------
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             ovf_o,
    output logic             sign_o
);

    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH-1:0] cin_s;
    logic [WIDTH-1:0] sum_s;

    // Operand conditioning and the single shared adder. The +1 of the
    // two's-complement negate enters as the carry-in.
    always_comb begin
        b_eff_s = {WIDTH{1'b0}};
        cin_s   = {WIDTH{1'b0}};
        if (sub_i) begin
            b_eff_s = ~b_i;
            cin_s   = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            b_eff_s = b_i;
            cin_s   = {WIDTH{1'b0}};
        end
        sum_s = a_i + b_eff_s + cin_s;
    end

    // Overflow is judged against the effective second operand: operands of
    // equal sign producing a result of the other sign. With b inverted this
    // is exactly the subtract rule (signs of a and b differ, result sign
    // differs from a).
    assign ovf_o  = (a_i[WIDTH-1] == b_eff_s[WIDTH-1]) &&
                    (sum_s[WIDTH-1] != a_i[WIDTH-1]);
    assign sum_o  = sum_s;
    assign sign_o = sum_s[WIDTH-1];

endmodule

// File: rtl/alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec
// 32-bit MIPS-style execute-stage ALU with registered result and flags.
// Operands sampled on a rising edge with in_valid=1 appear on the outputs
// after that edge; with in_valid=0 the result and flags hold and out_valid
// drops. One result per cycle, no stall.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : A, B and ALUctrl are valid this cycle
//   A, B      : operands (rs, rt/immediate)
//   ALUctrl   : operation select (see alu_pkg)
//   res       : registered result
//   zero      : registered, 1 when res == 0
//   overflow  : registered signed overflow for ADD/SUB, else 0
//   out_valid : registered copy of in_valid
// -----------------------------------------------------------------------------
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUctrl,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             overflow,
    output logic             out_valid
);

    logic             sub_s;
    logic [WIDTH-1:0] sum_s;
    logic             ovf_s;
    logic             sign_s;
    logic             lt_s;

    logic [WIDTH-1:0] alu_res_s;
    logic             alu_ovf_s;

    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] res_q;
    logic             zero_d;
    logic             zero_q;
    logic             ovf_d;
    logic             ovf_q;
    logic             valid_d;
    logic             valid_q;

    assign sub_s = alu_uses_sub(ALUctrl);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a_i    (A),
        .b_i    (B),
        .sub_i  (sub_s),
        .sum_o  (sum_s),
        .ovf_o  (ovf_s),
        .sign_o (sign_s)
    );

    // Signed less-than: the sign of A - B is wrong exactly when the
    // subtraction overflowed, so XOR corrects it.
    assign lt_s = sign_s ^ ovf_s;

    // Opcode mux; reserved and undefined codes produce zero with no overflow.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_ovf_s = 1'b0;
        case (ALUctrl)
            ALU_AND: begin
                alu_res_s = A & B;
                alu_ovf_s = 1'b0;
            end
            ALU_OR: begin
                alu_res_s = A | B;
                alu_ovf_s = 1'b0;
            end
            ALU_ADD: begin
                alu_res_s = sum_s;
                alu_ovf_s = ovf_s;
            end
            ALU_SUB: begin
                alu_res_s = sum_s;
                alu_ovf_s = ovf_s;
            end
            ALU_SLT: begin
                alu_res_s = {{(WIDTH-1){1'b0}}, lt_s};
                alu_ovf_s = 1'b0;
            end
            ALU_NOR: begin
                alu_res_s = ~(A | B);
                alu_ovf_s = 1'b0;
            end
            default: begin
                alu_res_s = {WIDTH{1'b0}};
                alu_ovf_s = 1'b0;
            end
        endcase
    end

    // Next-state for the output registers. zero is derived from the same
    // value that is loaded into res, so the two registers always agree.
    always_comb begin
        res_d   = res_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        valid_d = in_valid;
        if (in_valid) begin
            res_d  = alu_res_s;
            zero_d = (alu_res_s == {WIDTH{1'b0}});
            ovf_d  = alu_ovf_s;
        end else begin
            res_d  = res_q;
            zero_d = zero_q;
            ovf_d  = ovf_q;
        end
    end

    // Output registers; reset clears any in-flight result immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= {WIDTH{1'b0}};
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign res       = res_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_exec.sv
// -----------------------------------------------------------------------------
// tb_alu_exec
// Directed-vector bench for alu_exec with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_alu_exec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic [2:0]  ctrl_s;
    logic [31:0] res_s;
    logic        zero_s;
    logic        ovf_s;
    logic        out_valid_s;

    int tests_run    = 0;
    int tests_failed = 0;

    alu_exec #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a_s),
        .B         (b_s),
        .ALUctrl   (ctrl_s),
        .res       (res_s),
        .zero      (zero_s),
        .overflow  (ovf_s),
        .out_valid (out_valid_s)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (obs !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] e_res,
                              input logic e_zero, input logic e_ovf, input logic e_valid);
        check({tag, ".res"},       res_s,                 e_res);
        check({tag, ".zero"},      {31'd0, zero_s},      {31'd0, e_zero});
        check({tag, ".overflow"},  {31'd0, ovf_s},       {31'd0, e_ovf});
        check({tag, ".out_valid"}, {31'd0, out_valid_s}, {31'd0, e_valid});
    endtask

    // Drive one operation at the falling edge, check just after the next rise.
    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_res, input logic e_zero, input logic e_ovf);
        @(negedge clk);
        in_valid = 1'b1;
        ctrl_s   = op;
        a_s      = a;
        b_s      = b;
        @(posedge clk);
        #1;
        check_outs(tag, e_res, e_zero, e_ovf, 1'b1);
    endtask

    // Idle cycle with changed inputs: outputs must hold.
    task automatic do_idle(input string tag, input logic [31:0] e_res,
                           input logic e_zero, input logic e_ovf);
        @(negedge clk);
        in_valid = 1'b0;
        ctrl_s   = 3'b010;
        a_s      = 32'h7FFF_FFFF;
        b_s      = 32'h0000_0001;
        @(posedge clk);
        #1;
        check_outs(tag, e_res, e_zero, e_ovf, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a_s      = 32'd0;
        b_s      = 32'd0;
        ctrl_s   = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check_outs("por", 32'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load a non-zero result, then reset asynchronously mid-cycle.
        do_op("pre_rst", 3'b001, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        ctrl_s   = 3'b001;
        a_s      = 32'h1234_5678;
        b_s      = 32'h0000_0000;
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 32'd0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_outs("rst_hold_edge", 32'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outs("rst_release_idle", 32'd0, 1'b1, 1'b0, 1'b0);

        // Sweep with A=0, B=0xDEADBEEF.
        do_op("sw_and", 3'b000, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 1'b0);
        do_op("sw_or",  3'b001, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        do_op("sw_add", 3'b010, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        do_op("sw_sub", 3'b110, 32'h0000_0000, 32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b0);
        do_op("sw_slt", 3'b111, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 1'b0);
        do_op("sw_nor", 3'b100, 32'h0000_0000, 32'hDEAD_BEEF, 32'h2152_4110, 1'b0, 1'b0);

        // Overflow cases.
        do_op("add_ovf",  3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        do_op("sub_ovf",  3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);
        do_op("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        do_op("sub_neg",  3'b110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0);

        // SLT signed edges (the first one overflows inside the subtractor).
        do_op("slt_minmax", 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        do_op("slt_equal",  3'b111, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0);
        do_op("slt_neg1",   3'b111, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
        do_op("slt_maxmin", 3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0);

        // NOR and reserved codes.
        do_op("nor",    3'b100, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hF000_F000, 1'b0, 1'b0);
        do_op("rsv011", 3'b011, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        do_op("or_nz",  3'b001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
        do_op("rsv101", 3'b101, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0);

        // Back-to-back valid ops, then idle cycles: last result holds.
        do_op("pipe0", 3'b000, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 1'b0, 1'b0);
        do_op("pipe1", 3'b001, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0);
        do_op("pipe2", 3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        do_idle("hold0", 32'h8000_0000, 1'b0, 1'b1);
        do_idle("hold1", 32'h8000_0000, 1'b0, 1'b1);
        do_op("pipe3", 3'b110, 32'h0000_0010, 32'h0000_0010, 32'h0000_0000, 1'b1, 1'b0);
        do_idle("hold2", 32'h0000_0000, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
